// File: rtl/bit4_shift_register_slow.sv
// 4-bit serial-in shift register advanced by a divided slow clock.
// Fully synchronous to clk; clk2 is an observable output only.
module bit4_shift_register_slow #(
  parameter int unsigned DIV_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       data_in,
  output logic [3:0] q,
  output logic       clk2
);

  localparam logic [31:0] CNT_LAST = 32'(DIV_HALF - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        clk2_q;
  logic        clk2_d;
  logic [3:0]  q_q;
  logic [3:0]  q_d;
  logic        wrap;
  logic        shift_en;

  // Terminal count of the half-period divider.
  assign wrap = (cnt_q == CNT_LAST);

  // The shift fires only on the edge where clk2 goes 0 -> 1.
  assign shift_en = wrap & ~clk2_q;

  // Divider counter wraps at the end of each half-period.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (wrap) begin
      cnt_d = '0;
    end
  end

  // Slow clock flips together with the counter wrap.
  always_comb begin
    clk2_d = clk2_q;
    if (wrap) begin
      clk2_d = ~clk2_q;
    end
  end

  // Newest bit enters at q[0]; otherwise the register holds.
  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = {q_q[2:0], data_in};
    end
  end

  // State update; clr discards any partial count or pattern.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      clk2_q <= 1'b0;
      q_q    <= 4'b0000;
    end else begin
      cnt_q  <= cnt_d;
      clk2_q <= clk2_d;
      q_q    <= q_d;
    end
  end

  assign q    = q_q;
  assign clk2 = clk2_q;

endmodule

// File: tb/tb_bit4_shift_register_slow.sv
// Randomized self-checking bench for bit4_shift_register_slow.
// Reference model counts clk edges since release and derives clk2/q arithmetically.
module tb_bit4_shift_register_slow;

  localparam int D = 2;

  logic       clk;
  logic       clr;
  logic       data_in;
  logic [3:0] q;
  logic       clk2;

  logic       clr1;
  logic       din1;
  logic [3:0] q1;
  logic       clk2_1;

  int checks;
  int passed;

  int         n;
  logic [3:0] exp_q;
  logic       exp_clk2;

  bit4_shift_register_slow #(.DIV_HALF(D)) u_dut (
    .clk(clk),
    .clr(clr),
    .data_in(data_in),
    .q(q),
    .clk2(clk2)
  );

  bit4_shift_register_slow #(.DIV_HALF(1)) u_dut1 (
    .clk(clk),
    .clr(clr1),
    .data_in(din1),
    .q(q1),
    .clk2(clk2_1)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic next_is_shift(input int edges);
    int k;
    k = edges + 1;
    return (k % D == 0) && (((k / D) % 2) == 1);
  endfunction

  // Drive one bit (with a glitch between edges), take one edge, update model.
  task automatic advance(input logic din);
    data_in = ~din;
    #10;
    data_in = din;
    @(posedge clk);
    #1;
    n = n + 1;
    if ((n % D == 0) && (((n / D) % 2) == 1))
      exp_q = {exp_q[2:0], din};
    exp_clk2 = logic'((n / D) % 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    exp_q = 4'b0000;
    exp_clk2 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1;
    #10;
    checks++;
    if (q !== 4'b0000 || clk2 !== 1'b0)
      $display("FAIL reset_async q=%b clk2=%b exp q=0000 clk2=0", q, clk2);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'b0000 || clk2 !== 1'b0)
      $display("FAIL reset_hold q=%b clk2=%b exp q=0000 clk2=0", q, clk2);
    else passed++;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    exp_q = 4'b0000;
    exp_clk2 = 1'b0;
  endtask

  task automatic test_fill_ones();
    for (int i = 0; i < 16; i++) begin
      advance(1'b1);
      checks++;
      if (q !== exp_q || clk2 !== exp_clk2)
        $display("FAIL fill edge=%0d q=%b clk2=%b exp q=%b clk2=%b",
                 n, q, clk2, exp_q, exp_clk2);
      else passed++;
      if (n == 14) begin
        checks++;
        if (q !== 4'b1111 || clk2 !== 1'b1)
          $display("FAIL fill_edge14 q=%b clk2=%b exp q=1111 clk2=1", q, clk2);
        else passed++;
      end
    end
  endtask

  task automatic test_drain_zeros();
    for (int i = 0; i < 16; i++) begin
      advance(1'b0);
      checks++;
      if (q !== exp_q || clk2 !== exp_clk2)
        $display("FAIL drain edge=%0d q=%b clk2=%b exp q=%b clk2=%b",
                 n, q, clk2, exp_q, exp_clk2);
      else passed++;
    end
    checks++;
    if (q !== 4'b0000)
      $display("FAIL drain_final q=%b exp 0000", q);
    else passed++;
  endtask

  task automatic test_pattern();
    logic [3:0] pat;
    int idx;
    logic b;
    pat = 4'b1011;
    idx = 3;
    while (idx >= 0) begin
      if (next_is_shift(n)) begin
        b = pat[idx];
        idx--;
      end else begin
        b = logic'($urandom_range(0, 1));
      end
      advance(b);
      checks++;
      if (q !== exp_q || clk2 !== exp_clk2)
        $display("FAIL pattern edge=%0d q=%b clk2=%b exp q=%b clk2=%b",
                 n, q, clk2, exp_q, exp_clk2);
      else passed++;
    end
    checks++;
    if (q !== 4'b1011)
      $display("FAIL pattern_final q=%b exp 1011", q);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      advance(logic'($urandom_range(0, 1)));
      if (n % (2 * D) == D) break;
      checks++;
      if (q !== 4'b1011)
        $display("FAIL pattern_hold q=%b exp 1011", q);
      else passed++;
    end
  endtask

  task automatic test_period();
    logic last;
    int run;
    int phases;
    last = clk2;
    run = 0;
    phases = -1;
    for (int i = 0; i < 40 && phases < 16; i++) begin
      advance(logic'($urandom_range(0, 1)));
      run++;
      if (clk2 !== last) begin
        if (phases >= 0) begin
          checks++;
          if (run != D)
            $display("FAIL period_phase len=%0d exp %0d", run, D);
          else passed++;
        end
        phases++;
        run = 0;
        last = clk2;
      end
    end
    checks++;
    if (phases < 16)
      $display("FAIL period_timeout phases=%0d exp 16", phases);
    else passed++;
  endtask

  task automatic test_async_clear();
    do_reset();
    for (int i = 0; i < 10; i++) advance(1'b1);
    checks++;
    if (q !== 4'b0111 || clk2 !== 1'b1)
      $display("FAIL clear_pre q=%b clk2=%b exp q=0111 clk2=1", q, clk2);
    else passed++;
    #20;
    clr = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000 || clk2 !== 1'b0)
      $display("FAIL clear_async q=%b clk2=%b exp q=0000 clk2=0", q, clk2);
    else passed++;
    #10;
    clr = 1'b0;
    n = 0;
    exp_q = 4'b0000;
    exp_clk2 = 1'b0;
    advance(1'b1);
    checks++;
    if (q !== 4'b0000 || clk2 !== 1'b0)
      $display("FAIL clear_edge1 q=%b clk2=%b exp q=0000 clk2=0", q, clk2);
    else passed++;
    advance(1'b1);
    checks++;
    if (q !== 4'b0001 || clk2 !== 1'b1)
      $display("FAIL clear_edge2 q=%b clk2=%b exp q=0001 clk2=1", q, clk2);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (i == 97) begin
        do_reset();
      end
      advance(logic'($urandom_range(0, 1)));
      checks++;
      if (q !== exp_q || clk2 !== exp_clk2)
        $display("FAIL random edge=%0d q=%b clk2=%b exp q=%b clk2=%b",
                 n, q, clk2, exp_q, exp_clk2);
      else passed++;
    end
  endtask

  task automatic test_div1();
    int k;
    logic [3:0] mq;
    @(negedge clk);
    clr1 = 1'b1;
    din1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    k = 0;
    mq = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (k % 2 == 1) mq = {mq[2:0], 1'b1};
      checks++;
      if (q1 !== mq || clk2_1 !== logic'(k % 2))
        $display("FAIL div1 edge=%0d q=%b clk2=%b exp q=%b clk2=%b",
                 k, q1, clk2_1, mq, logic'(k % 2));
      else passed++;
    end
    checks++;
    if (q1 !== 4'b1111)
      $display("FAIL div1_final q=%b exp 1111", q1);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    clr = 1'b1;
    clr1 = 1'b1;
    data_in = 1'b0;
    din1 = 1'b0;
    n = 0;
    exp_q = 4'b0000;
    exp_clk2 = 1'b0;
    #5;
    test_reset();
    test_fill_ones();
    test_drain_zeros();
    test_pattern();
    test_period();
    test_async_clear();
    test_random();
    test_div1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
